// File: rtl/rr_mux_arbiter_4_pkg.sv
// Shared encodings for the four-way round-robin output arbiter.
// FSM state values, requester count and the pointer reset value.
package rr_mux_arbiter_4_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/rr_pick_4.sv
// Round-robin pick: first set req bit scanning upward from last+1, wrapping 3->0.
// Purely combinational (0 cycles); has no flow control of its own.
module rr_pick_4
    import rr_mux_arbiter_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         pick,
    output logic               any
);

    logic [1:0]         base;
    logic [NUM_REQ-1:0] rot;
    logic [1:0]         off;

    assign base = last + 2'd1;
    assign any  = |req;

    // Rotate so the highest-priority requester lands on bit 0, encode, rotate back.
    always_comb begin
        rot = '0;
        off = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[base + 2'(i)];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = 2'(i);
            end
        end
    end

    assign pick = base + off;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin mux into a one-entry registered output; 1-cycle latency.
// Backpressure: while full and out_ready=0 no grant is issued and out_data holds.
module rr_mux_arbiter_4
    import rr_mux_arbiter_4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   data_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [1:0]                 select,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 tx_count
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last;
    logic [1:0] pick;
    logic       any;
    logic       load;

    rr_pick_4 u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    assign out_valid = (state == ST_FULL);

    // A load may overlap an unload, which keeps the stage full at full rate.
    always_comb begin
        state_nxt = state;
        grant     = '0;
        load      = !rst && (!out_valid || out_ready) && any;
        if (load) begin
            grant[pick] = 1'b1;
            state_nxt   = ST_FULL;
        end else if (out_valid && out_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            select   <= 2'd0;
            last     <= LAST_RST;
            tx_count <= 8'd0;
        end else begin
            if (load) begin
                out_data <= data_in[pick*WIDTH +: WIDTH];
                select   <= pick;
                last     <= pick;
            end
            if (out_valid && out_ready) begin
                tx_count <= tx_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed and randomised stimulus for rr_mux_arbiter_4 with a word scoreboard.
module tb_rr_mux_arbiter_4;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic [3:0]     grant;
    logic [1:0]     select;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     tx_count;

    logic [W-1:0]   dat [4];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [1:0]    m_last;
    logic          m_valid;
    logic [7:0]    m_tx;
    logic [W-1:0]  m_data;
    logic [1:0]    m_sel;
    logic          m_pend;
    logic [W+1:0]  sb [$];
    logic [3:0]    g;

    always #5 clk = ~clk;

    assign data_in = {dat[3], dat[2], dat[1], dat[0]};

    rr_mux_arbiter_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .select    (select),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tx_count  (tx_count)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        for (int k = 1; k <= 4; k++) begin
            idx = l + 2'(k);
            if (r[idx]) return {1'b1, 2'b00, idx};
        end
        return 5'b0;
    endfunction

    // Called just after a falling edge: drive, check, advance the model across the next rising edge.
    task automatic cycle(input logic [3:0] r, input logic rdy, input logic rs, output logic [3:0] gnt);
        logic [4:0] p;
        logic [3:0] eg;
        logic [W+1:0] e;
        logic       ld;
        req = r;
        out_ready = rdy;
        rst = rs;
        #1;
        if (m_pend) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $error("FAIL sb_underflow observed=empty expected=word");
            end else begin
                n_chk--;
                e = sb.pop_front();
                m_sel  = e[W+1:W];
                m_data = e[W-1:0];
            end
        end
        chk("out_valid", W'(out_valid), W'(m_valid));
        chk("out_data", out_data, m_data);
        chk("select", W'(select), W'(m_sel));
        chk("tx_count", W'(tx_count), W'(m_tx));
        p  = model_pick(r, m_last);
        ld = !rs && (!m_valid || rdy) && p[4];
        eg = ld ? (4'b0001 << p[1:0]) : 4'b0000;
        chk("grant", W'(grant), W'(eg));
        gnt = grant;
        if (rs) begin
            sb.delete();
            m_last = 2'd3; m_valid = 1'b0; m_tx = 8'd0;
            m_data = '0;   m_sel = 2'd0;   m_pend = 1'b0;
        end else begin
            if (m_valid && rdy) m_tx = m_tx + 8'd1;
            if (ld) begin
                sb.push_back({p[1:0], dat[p[1:0]]});
                m_last  = p[1:0];
                m_valid = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            m_pend = ld;
        end
        @(negedge clk);
    endtask

    initial begin
        dat[0] = 32'h11111111; dat[1] = 32'h22222222;
        dat[2] = 32'h33333333; dat[3] = 32'h44444444;
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
        m_last = 2'd3; m_valid = 1'b0; m_tx = 8'd0;
        m_data = '0; m_sel = 2'd0; m_pend = 1'b0;
        @(negedge clk);

        // Reset held two cycles with all requesting
        cycle(4'b1111, 1'b1, 1'b1, g);
        chk("rst_grant0", W'(g), 32'd0);
        cycle(4'b1111, 1'b1, 1'b1, g);
        chk("rst_grant1", W'(g), 32'd0);

        // Fair rotation, two full rounds
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b1, 1'b0, g);
            chk("rr_grant", W'(g), W'(4'b0001 << (i % 4)));
        end
        chk("rr_tx", W'(tx_count), 32'd7);
        cycle(4'b0000, 1'b1, 1'b0, g);
        cycle(4'b0000, 1'b1, 1'b0, g);

        // Backpressure
        cycle(4'b0011, 1'b0, 1'b0, g);
        chk("bp_first", W'(g), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0011, 1'b0, 1'b0, g);
            chk("bp_hold_grant", W'(g), 32'd0);
            chk("bp_hold_data", out_data, 32'h11111111);
        end
        cycle(4'b0011, 1'b1, 1'b0, g);
        chk("bp_release", W'(g), 32'd2);
        cycle(4'b0000, 1'b1, 1'b0, g);
        chk("bp_next_data", out_data, 32'h22222222);

        // Sole requester 2, then drop
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0100, 1'b1, 1'b0, g);
            chk("solo_grant", W'(g), 32'd4);
        end
        cycle(4'b0000, 1'b1, 1'b0, g);
        chk("solo_sel", W'(select), 32'd2);
        cycle(4'b0000, 1'b1, 1'b0, g);
        chk("solo_drained", W'(out_valid), 32'd0);

        // Reset mid-transfer while full with select=2
        cycle(4'b0100, 1'b0, 1'b0, g);
        cycle(4'b0100, 1'b0, 1'b0, g);
        chk("mid_full_sel", W'(select), 32'd2);
        cycle(4'b1111, 1'b0, 1'b1, g);
        cycle(4'b1111, 1'b1, 1'b0, g);
        chk("mid_after_rst", W'(g), 32'd1);

        // Long back-to-back run across the tx_count wrap with changing data
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) dat[k] = $urandom;
            cycle(4'b1111, 1'b1, 1'b0, g);
        end

        // Random traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) dat[k] = $urandom;
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0), g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
